// File: rtl/pierogi_stream_pkg.sv
// Shared stream constants: default word width, port select codes and a
// pointer-width helper for the demux FIFOs.
package pierogi_stream_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_sel_e;

  // Number of bits needed to index 'value' entries (value >= 2).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/demux_stream_if.sv
// Producer-side and consumer-side stream signals of the 1:2 demux.
interface demux_stream_if
  import pierogi_stream_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;

  modport slave (
    input  in_valid, in_data, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport master (
    output in_valid, in_data, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );
endinterface

// File: rtl/demux_fifo.sv
// Synchronous FIFO with registered storage; head is the entry at rd_ptr.
// Push is ignored when full, pop is ignored when empty.
module demux_fifo
  import pierogi_stream_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int unsigned PW = clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // Storage is cleared too so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + CW'(1);
      else if (!w_push_ok && w_pop_ok) r_count <= r_count - CW'(1);
    end
  end
endmodule

// File: rtl/demux_stream.sv
// 1-to-2 buffered stream demultiplexer: steers each accepted word by in_sel
// into one of two per-port FIFOs.
module demux_stream
  import pierogi_stream_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = 2
) (
  input logic           clk,
  input logic           rst_n,
  demux_stream_if.slave bus
);
  logic w_full0, w_full1;
  logic w_empty0, w_empty1;
  logic w_sel_full;
  logic w_accept;
  logic w_push0, w_push1;

  // Only the selected port's full flag gates the producer; no bypass across ports.
  always_comb begin
    w_sel_full = (port_sel_e'(bus.in_sel) == PORT1) ? w_full1 : w_full0;
  end

  assign bus.in_ready = rst_n & ~w_sel_full;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_push0      = w_accept & (port_sel_e'(bus.in_sel) == PORT0);
  assign w_push1      = w_accept & (port_sel_e'(bus.in_sel) == PORT1);

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push0),
    .i_data  (bus.in_data),
    .i_pop   (bus.out0_ready),
    .o_full  (w_full0),
    .o_empty (w_empty0),
    .o_head  (bus.out0_data)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push1),
    .i_data  (bus.in_data),
    .i_pop   (bus.out1_ready),
    .o_full  (w_full1),
    .o_empty (w_empty1),
    .o_head  (bus.out1_data)
  );

  assign bus.out0_valid = ~w_empty0;
  assign bus.out1_valid = ~w_empty1;
endmodule
